// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the pipeline: stage register layout, funct3 codes
// and the memory-stage FSM states.
package mem_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] rv32i_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
    } ctrl_t;

    // mdr is filled in by the memory stage; earlier stages pass it through.
    typedef struct packed {
        rv32i_word  pc;
        rv32i_word  alu;
        rv32i_word  rs2;
        rv32i_word  mdr;
        logic [4:0] rd;
        logic [2:0] funct3;
        ctrl_t      ctrl;
        logic       valid;
    } stage_regs;

    localparam int STAGE_REGS_W = $bits(stage_regs);

    // Access width implied by a load funct3; stores use the same codes for
    // their three defined encodings. Undefined codes have no width, so they
    // can never be flagged misaligned.
    function automatic access_size_t access_size(input logic [2:0] funct3);
        access_size_t size;
        case (load_funct3_t'(funct3))
            lb, lbu: size = SZ_BYTE;
            lh, lhu: size = SZ_HALF;
            lw:      size = SZ_WORD;
            default: size = SZ_NONE;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data memory: store lane replication and byte
// enables, load shift plus sign/zero extension, and alignment check.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_enable,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    access_size_t size;
    logic [31:0]  shifted;

    // Halfwords must sit on an even byte, words on a word boundary.
    always_comb begin
        size       = access_size(funct3);
        misaligned = ((size == SZ_HALF) && offset[0]) ||
                     ((size == SZ_WORD) && (offset != 2'b00));
    end

    // Replicate store data across lanes so the enabled lanes carry it.
    always_comb begin
        byte_enable = 4'b0000;
        wdata       = rs2;
        case (store_funct3_t'(funct3))
            sb: begin
                byte_enable = 4'b0001 << offset;
                wdata       = {4{rs2[7:0]}};
            end
            sh: begin
                byte_enable = 4'b0011 << offset;
                wdata       = {2{rs2[15:0]}};
            end
            sw: byte_enable = 4'b1111;
            default: byte_enable = 4'b0000;
        endcase
    end

    // Move the addressed byte/halfword to bit 0, then extend.
    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        load_data = '0;
        case (load_funct3_t'(funct3))
            lb:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     load_data = {24'h000000, shifted[7:0]};
            lh:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     load_data = {16'h0000, shifted[15:0]};
            lw:      load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline stage 4: issues data-memory loads/stores over a request/response
// handshake, stalls upstream while an access is outstanding, and registers
// the result (with aligned load data in mdr) for writeback.
//
// Handshake: dmem_read/dmem_write are registered requests that stay high,
// with address/byte_enable/wdata stable, until the cycle in which dmem_resp
// is sampled high; dmem_resp is a one-cycle pulse and dmem_rdata is only
// meaningful in that cycle. Responses outside BUSY are ignored.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int width = 32  // only 32 is supported
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [STAGE_REGS_W-1:0] regs_in,
    output logic [STAGE_REGS_W-1:0] regs_out,
    output logic                    stall,
    output logic                    misaligned,
    output logic [width-1:0]        dmem_address,
    output logic                    dmem_read,
    output logic                    dmem_write,
    output logic [3:0]              dmem_byte_enable,
    output logic [width-1:0]        dmem_wdata,
    input  logic [width-1:0]        dmem_rdata,
    input  logic                    dmem_resp,
    output logic [1:0]              state_dbg
);

    stage_regs  in_r;
    stage_regs  out_q;
    stage_regs  out_d;
    logic       mis_d;

    mem_state_t state_q;
    mem_state_t state_d;

    logic       mem_op;
    logic       access_ok;

    // Fields of the in-flight access, held so formatting does not depend
    // on regs_in once the request has gone out.
    logic [2:0] funct3_q;
    logic [1:0] off_q;
    logic       load_q;
    rv32i_word  mdr_q;

    logic [2:0]  align_funct3;
    logic [1:0]  align_off;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [31:0] load_w;
    logic        mis_w;

    assign in_r      = stage_regs'(regs_in);
    assign regs_out  = out_q;
    assign state_dbg = state_q;

    assign mem_op    = in_r.valid & (in_r.ctrl.mem_read | in_r.ctrl.mem_write);
    assign access_ok = mem_op & ~mis_w;

    // Idle: format the incoming instruction; otherwise: the latched access.
    assign align_funct3 = (state_q == IDLE) ? in_r.funct3    : funct3_q;
    assign align_off    = (state_q == IDLE) ? in_r.alu[1:0]  : off_q;

    mem_align u_align (
        .funct3      (align_funct3),
        .offset      (align_off),
        .rs2         (in_r.rs2),
        .rdata       (dmem_rdata),
        .byte_enable (be_w),
        .wdata       (wdata_w),
        .load_data   (load_w),
        .misaligned  (mis_w)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: aligned access goes out, waits for the response,
    // then spends one cycle releasing the instruction to writeback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access_ok) state_d = BUSY;
            BUSY:    if (dmem_resp) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: hold upstream from the cycle an access is accepted until
    // the response has been captured.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = access_ok;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Request registers: launch on acceptance, drop the cycle after dmem_resp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_address     <= '0;
            dmem_byte_enable <= 4'b0000;
            dmem_wdata       <= '0;
            funct3_q         <= 3'b000;
            off_q            <= 2'b00;
            load_q           <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access_ok) begin
                        // A request carrying both flags is treated as a read.
                        dmem_read        <= in_r.ctrl.mem_read;
                        dmem_write       <= ~in_r.ctrl.mem_read;
                        dmem_address     <= {in_r.alu[31:2], 2'b00};
                        dmem_byte_enable <= in_r.ctrl.mem_read ? 4'b0000 : be_w;
                        dmem_wdata       <= in_r.ctrl.mem_read ? 32'h0 : wdata_w;
                        funct3_q         <= in_r.funct3;
                        off_q            <= in_r.alu[1:0];
                        load_q           <= in_r.ctrl.mem_read;
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Capture formatted load data on the response; stores leave mdr zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdr_q <= '0;
        end else if ((state_q == BUSY) && dmem_resp) begin
            mdr_q <= load_q ? load_w : 32'h0;
        end
    end

    // Next stage-register contents: a bubble while stalled so writeback
    // sees every instruction exactly once.
    always_comb begin
        out_d = '0;
        mis_d = 1'b0;
        if (!stall) begin
            out_d = in_r;
            if (state_q == DONE) begin
                out_d.mdr = mdr_q;
            end else begin
                out_d.mdr = '0;
                mis_d     = mem_op & mis_w;
            end
        end
    end

    // Stage register to writeback, loaded every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            misaligned <= 1'b0;
        end else begin
            out_q      <= out_d;
            misaligned <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random instruction mix, with a
// stalling upstream driver, a variable-latency memory responder and an
// output monitor popping expected results from queues.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int W = STAGE_REGS_W + 1;  // {misaligned, regs_out}

  logic                    clk;
  logic                    rst_n;
  logic [STAGE_REGS_W-1:0] regs_in;
  logic [STAGE_REGS_W-1:0] regs_out;
  logic                    stall;
  logic                    misaligned;
  logic [31:0]             dmem_address;
  logic                    dmem_read;
  logic                    dmem_write;
  logic [3:0]              dmem_byte_enable;
  logic [31:0]             dmem_wdata;
  logic [31:0]             dmem_rdata;
  logic                    dmem_resp;
  logic [1:0]              state_dbg;

  stage_regs ro;
  assign ro = stage_regs'(regs_out);

  mem_stage #(.width(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .regs_in          (regs_in),
    .regs_out         (regs_out),
    .stall            (stall),
    .misaligned       (misaligned),
    .dmem_address     (dmem_address),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_wdata       (dmem_wdata),
    .dmem_rdata       (dmem_rdata),
    .dmem_resp        (dmem_resp),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  int            cyc_q[$];
  logic [69:0]   req_q[$];   // {read, write, address, byte_enable, wdata}

  int          mem_wait = 0;
  logic [31:0] mem_rdata = 32'h0;
  bit          mem_en = 1'b1;
  bit          stray_resp = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [2:0] f3);
    int f;
    f = int'(f3);
    if (f == 0 || f == 4) return 1;
    if (f == 1 || f == 5) return 2;
    if (f == 2) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] f3, input int off, input logic [31:0] rd);
    longint v;
    int sz;
    sz = size_bytes(f3);
    if (sz == 0) return 32'h0;
    v = longint'(rd >> (8 * off));
    if (sz < 4) v = v % (longint'(1) << (8 * sz));
    if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return 32'(v);
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input stage_regs x, input int wt, input logic [31:0] rdata);
    int off, sz, n;
    bit memop, mis, ld, ok;
    stage_regs e;
    logic [3:0]  be;
    logic [31:0] wd;
    off   = int'(x.alu % 4);
    sz    = size_bytes(x.funct3);
    memop = x.valid && (x.ctrl.mem_read || x.ctrl.mem_write);
    mis   = memop && ((sz == 2 && off % 2 == 1) || (sz == 4 && off != 0));
    ld    = x.ctrl.mem_read;
    if (x.valid) begin
      e = x;
      e.mdr = 32'h0;
      if (memop && !mis && ld) e.mdr = load_model(x.funct3, off, rdata);
      exp_q.push_back({mis, e});
      cyc_q.push_back(cyc + ((memop && !mis) ? 3 + wt : 1));
    end
    if (memop && !mis) begin
      be = 4'h0;
      wd = 32'h0;
      if (!ld) begin
        be = 4'(((1 << sz) - 1) << off);
        if (sz == 1) wd = (x.rs2 % 256) * 32'h01010101;
        else if (sz == 2) wd = (x.rs2 % 65536) * 32'h00010001;
        else wd = x.rs2;
      end
      req_q.push_back({ld, !ld, x.alu - 32'(off), be, wd});
    end
    mem_wait  = wt;
    mem_rdata = rdata;
    regs_in   = x;
    ok = 1'b0;
    for (n = 0; n < 64; n++) begin
      @(negedge clk);
      if (!stall) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL stall_timeout: stall still high after 64 cycles, required low");
    end
    @(posedge clk);
    #1;
    regs_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic stage_regs mk(input int kind, input logic [2:0] f3, input logic [31:0] alu,
                                   input logic [31:0] rs2);
    stage_regs x;
    x = '0;
    x.pc     = 32'h1000 + alu;
    x.rd     = 5'd7;
    x.alu    = alu;
    x.rs2    = rs2;
    x.funct3 = f3;
    x.valid  = 1'b1;
    x.ctrl.mem_read  = (kind == 1);
    x.ctrl.mem_write = (kind == 2);
    x.ctrl.reg_write = (kind != 2);
    return x;
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    int waited;
    waited = 0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      if (!mem_en) begin
        dmem_resp = stray_resp;
        waited = 0;
      end else if (rst_n && (dmem_read || dmem_write)) begin
        if (req_q.size() == 0) begin
          chk("unexpected_request", {dmem_read, dmem_write, dmem_address}, 0);
        end else begin
          chk("request", {dmem_read, dmem_write, dmem_address, dmem_byte_enable, dmem_wdata}, req_q[0]);
          if (waited >= mem_wait) begin
            void'(req_q.pop_front());
            dmem_resp  = 1'b1;
            dmem_rdata = mem_rdata;
            waited = 0;
          end else begin
            waited++;
          end
        end
      end else begin
        waited = 0;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial forever begin
    logic [W-1:0] e;
    int ec;
    @(negedge clk);
    if (rst_n) begin
      if (dmem_read && dmem_write) chk("read_write_exclusive", 1, 0);
      if (ro.valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {misaligned, regs_out}, 0);
        end else begin
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          chk("regs_out", {misaligned, regs_out}, e);
          chk("latency_cycle", 160'(cyc), 160'(ec));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stage_regs x;
    int k;
    logic [2:0] ld_codes [8];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst_n   = 1'b0;
    regs_in = '0;
    #12;
    chk("reset_regs_out", regs_out, 0);
    chk("reset_misaligned", misaligned, 0);
    chk("reset_stall", stall, 0);
    chk("reset_requests", {dmem_read, dmem_write}, 0);
    chk("reset_addr_be_wdata", {dmem_address, dmem_byte_enable, dmem_wdata}, 0);
    chk("reset_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed
    issue(mk(0, 3'd0, 32'h10, 32'h5), 0, 32'h0);                 // ADD
    issue(mk(2, 3'd2, 32'h100, 32'hDEADBEEF), 2, 32'h0);         // SW
    issue(mk(2, 3'd0, 32'h203, 32'h000000A5), 1, 32'h0);         // SB
    issue(mk(1, 3'd0, 32'h302, 32'h0), 0, 32'h80F01234);         // LB
    issue(mk(1, 3'd4, 32'h302, 32'h0), 1, 32'h80F01234);         // LBU
    issue(mk(1, 3'd5, 32'h302, 32'h0), 0, 32'h80F01234);         // LHU
    issue(mk(1, 3'd2, 32'h105, 32'h0), 0, 32'h0);                // LW misaligned
    issue(mk(1, 3'd2, 32'h500, 32'h0), 0, 32'h11223344);         // LW
    issue(mk(1, 3'd2, 32'h504, 32'h0), 0, 32'hCAFEF00D);         // LW back-to-back
    issue(mk(1, 3'd6, 32'h606, 32'h0), 0, 32'hFFFFFFFF);         // undefined load
    idle(2);

    // reset while BUSY
    mem_en  = 1'b0;
    regs_in = mk(1, 3'd2, 32'h400, 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("busy_read_asserted", {dmem_read, stall}, 2'b11);
    #2;
    rst_n   = 1'b0;
    regs_in = '0;
    #1;
    chk("rst_drops_requests", {dmem_read, dmem_write}, 0);
    chk("rst_drops_valid", ro.valid, 0);
    chk("rst_state_idle", state_dbg, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_resp = 1'b1;
    @(negedge clk);
    stray_resp = 1'b0;
    @(negedge clk);
    chk("late_resp_ignored", {dmem_read, dmem_write, stall, ro.valid}, 0);
    chk("late_resp_state", state_dbg, IDLE);
    mem_en = 1'b1;
    @(posedge clk);
    #1;

    // random mix
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 2);
      x = mk(k, 3'd0, $urandom, $urandom);
      x.pc    = $urandom;
      x.rd    = 5'($urandom_range(0, 31));
      x.valid = ($urandom_range(0, 9) != 0);
      if (k == 0) x.funct3 = 3'($urandom_range(0, 7));
      else if (k == 1) x.funct3 = ld_codes[$urandom_range(0, 7)];
      else x.funct3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) x.alu = x.alu & 32'hFFFFFFFC;
      issue(x, $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    chk("outputs_outstanding", 160'(exp_q.size()), 0);
    chk("requests_outstanding", 160'(req_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4, directly downstream of the execute stage.
- Takes the execute stage's registered stage_regs and performs data-memory loads and stores through a request/response handshake.
- Aligns, extends and byte-enables the data, then registers the result for writeback.
- Stalls upstream stages while an access is outstanding.

Parameters:
- width, 32, data/address width in bits (only 32 supported).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- regs_in  in  $bits(stage_regs)  execute stage output (alu = address, rs2 = store data, funct3, ctrl, valid)
- regs_out  out  $bits(stage_regs)  registered to writeback; mdr field holds aligned load data
- stall  out  1  holds all upstream stage registers while high
- misaligned  out  1  registered with regs_out; instruction in regs_out was a suppressed misaligned access
- dmem_address  out  32  word-aligned address, {alu[31:2],2'b00}
- dmem_read  out  1  read request, registered
- dmem_write  out  1  write request, registered
- dmem_byte_enable  out  4  store byte lanes
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state IDLE; regs_out all zero (valid=0); misaligned, stall, dmem_read, dmem_write = 0; dmem_address, byte_enable, wdata = 0.
- Reset mid-access drops requests immediately; a late dmem_resp after reset is ignored.
- mem_op = regs_in.valid & (ctrl.mem_read | ctrl.mem_write); off = alu[1:0].
- Misaligned: halfword with off[0]=1, or word with off!=0.
  - No request is issued.
  - Handled as a non-memory op with mdr=0 and misaligned=1 in the same cycle regs_out updates.
- stall is combinational: high when (IDLE & mem_op & aligned) or BUSY; low in DONE.
- Stage register loads every cycle:
  - stall=0: loads regs_in plus computed mdr/misaligned.
  - stall=1: loads a bubble (valid=0, misaligned=0), so writeback sees each instruction exactly once.
- FSM:
  - IDLE: on aligned mem_op, latch address, byte_enable and wdata; assert dmem_read or dmem_write next cycle; go BUSY. Otherwise pass-through, 1-cycle latency.
  - BUSY: hold requests and address stable. On dmem_resp: capture formatted dmem_rdata into internal mdr_q, deassert requests next cycle, go DONE.
  - DONE: stall=0; regs_out loads regs_in with mdr=mdr_q (stores: mdr=0); go IDLE. Upstream advances this same edge, so the instruction is not re-issued.
- Minimum memory-op latency is 3 cycles from regs_in presentation to regs_out (0-wait memory).
- dmem_resp in IDLE or DONE is ignored; read and write are never both high.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<off.
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<off.
  - SW: wdata=rs2, be=4'b1111.
  - be=0 for loads.
- Load formatting: w = dmem_rdata>>(8*off).
  - LB/LH sign-extend w[7:0]/w[15:0]; LBU/LHU zero-extend; LW = dmem_rdata.
  - Undefined funct3 gives mdr=0, with access still performed.

Decomposition:
- rv32i_types gains:
  - mdr field (rv32i_word) in stage_regs, passed through unchanged by the execute stage;
  - mem_state_t enum {IDLE, BUSY, DONE};
  - existing load_funct3_t/store_funct3_t reused.
- One combinational sub-module, mem_align: funct3, offset, rs2 and rdata in; byte_enable, wdata, load data and misaligned flag out. mem_stage holds the FSM, request registers and stage register.

Test Plan:
- Non-mem ADD, alu=0x10 valid -> regs_out next cycle alu=0x10, stall never high, no dmem request.
- SW alu=0x100, rs2=0xDEADBEEF, resp after 2 wait cycles -> dmem_write=1, address=0x100, be=4'hF, wdata=0xDEADBEEF; stall high until DONE; one valid regs_out, bubbles while stalled.
- SB alu=0x203, rs2=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5, address=0x200.
- LB/LBU/LHU alu=0x302, rdata=0x80F0_1234:
  - LB -> mdr=0xFFFFFFF0;
  - LBU -> 0x000000F0;
  - LHU alu=0x302 -> 0x000080F0.
- LW alu=0x105 -> no request, stall=0, regs_out valid, misaligned=1, mdr=0.
- Back-to-back LW/LW with 0-wait resp -> each completes 3 cycles apart, correct mdr each; rst_n pulsed while BUSY -> requests and regs_out.valid drop immediately; a subsequent resp is ignored.
